// File: rtl/skeleton_sequencer.sv
// Host-side controller for one test skeleton: accepts host commands, runs the
// skeleton with a bounded wait, and returns results, header or statistics.
module skeleton_sequencer #(
  parameter int BITWIDTH_SYS   = 16,
  parameter int BITWIDTH_HEAD  = 26,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK_SYS,
  input  logic                     RSTN,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_OP,
  input  logic [BITWIDTH_SYS-1:0]  CMD_DATA,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [BITWIDTH_HEAD-1:0] RSP_DATA,
  output logic                     RSP_ERR,
  output logic                     DUT_EN,
  output logic                     DUT_TRGG,
  output logic [BITWIDTH_SYS-1:0]  DUT_DATA_IN,
  input  logic [BITWIDTH_SYS-1:0]  DUT_DATA_OUT,
  input  logic [BITWIDTH_HEAD-1:0] DUT_HEAD,
  input  logic                     DUT_VALID,
  output logic [1:0]               DBG_STATE,
  output logic [15:0]              DBG_RUN_CNT,
  output logic [15:0]              DBG_ERR_CNT
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // RSP_VALID/RSP_DATA/RSP_ERR stay frozen until that edge.

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] OP_READ_HEAD = 2'd0;
  localparam logic [1:0] OP_RUN       = 2'd1;
  localparam logic [1:0] OP_SET_EN    = 2'd2;
  localparam logic [1:0] OP_READ_STAT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            wait_cnt_q;
  logic [15:0]              run_cnt_q;
  logic [15:0]              err_cnt_q;
  logic                     rsp_valid_q;
  logic [BITWIDTH_HEAD-1:0] rsp_data_q;
  logic                     rsp_err_q;
  logic                     en_q;
  logic                     trgg_q;
  logic [BITWIDTH_SYS-1:0]  din_q;

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      run_cnt_q   <= '0;
      err_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      en_q        <= 1'b0;
      trgg_q      <= 1'b0;
      din_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID) begin
            case (CMD_OP)
              OP_READ_HEAD: begin
                rsp_data_q  <= DUT_HEAD;
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_SET_EN: begin
                en_q        <= CMD_DATA[0];
                rsp_data_q  <= BITWIDTH_HEAD'(CMD_DATA[0]);
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_READ_STAT: begin
                rsp_data_q  <= BITWIDTH_HEAD'({err_cnt_q[7:0], run_cnt_q[7:0]});
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              default: begin
                // A run on a disabled skeleton is refused without a trigger.
                if (en_q) begin
                  din_q   <= CMD_DATA;
                  trgg_q  <= 1'b1;
                  state_q <= S_TRIG;
                end else begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  err_cnt_q   <= err_cnt_q + 16'd1;
                  state_q     <= S_RESP;
                end
              end
            endcase
          end
        end
        S_TRIG: begin
          trgg_q     <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A result in the final wait cycle still wins over the timeout.
          if (DUT_VALID) begin
            rsp_data_q  <= BITWIDTH_HEAD'(DUT_DATA_OUT);
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            run_cnt_q   <= run_cnt_q + 16'd1;
            state_q     <= S_RESP;
          end else if (wait_cnt_q == TO_LIM) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            err_cnt_q   <= err_cnt_q + 16'd1;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign CMD_READY   = (state_q == S_IDLE);
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_ERR     = rsp_err_q;
  assign DUT_EN      = en_q;
  assign DUT_TRGG    = trgg_q;
  assign DUT_DATA_IN = din_q;
  assign DBG_STATE   = state_q;
  assign DBG_RUN_CNT = run_cnt_q;
  assign DBG_ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_skeleton_sequencer.sv
// Bench for skeleton_sequencer: a directed vector table, hand-written reset and
// backpressure sequences, then random commands against a transaction-level model.
`timescale 1ns/1ps
module tb_skeleton_sequencer;

  localparam int SYS  = 16;
  localparam int HEAD = 26;
  localparam int TO   = 8;

  localparam logic [1:0] OP_HEAD  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_SETEN = 2'd2;
  localparam logic [1:0] OP_STAT  = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [SYS-1:0]  cmd_data = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [HEAD-1:0] rsp_data;
  logic            rsp_err;
  logic            dut_en;
  logic            dut_trgg;
  logic [SYS-1:0]  dut_data_in;
  logic [SYS-1:0]  dut_data_out = '0;
  logic [HEAD-1:0] dut_head = '0;
  logic            dut_valid = 1'b0;
  logic [1:0]      dbg_state;
  logic [15:0]     dbg_run_cnt;
  logic [15:0]     dbg_err_cnt;

  skeleton_sequencer #(
    .BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEAD), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .CLK_SYS(clk), .RSTN(rstn),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_DATA(cmd_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .DUT_EN(dut_en), .DUT_TRGG(dut_trgg), .DUT_DATA_IN(dut_data_in),
    .DUT_DATA_OUT(dut_data_out), .DUT_HEAD(dut_head), .DUT_VALID(dut_valid),
    .DBG_STATE(dbg_state), .DBG_RUN_CNT(dbg_run_cnt), .DBG_ERR_CNT(dbg_err_cnt)
  );

  // Echo skeleton: result appears skel_lat cycles after the trigger cycle; 0 = never.
  int             skel_lat = 1;
  int             skel_cnt = 0;
  logic [SYS-1:0] skel_hold = '0;
  always @(posedge clk) begin
    dut_valid    <= 1'b0;
    dut_data_out <= SYS'($urandom);
    if (dut_trgg && skel_lat > 0) begin
      skel_hold <= dut_data_in;
      if (skel_lat == 1) begin
        dut_valid    <= 1'b1;
        dut_data_out <= dut_data_in;
      end else begin
        skel_cnt <= skel_lat - 1;
      end
    end else if (skel_cnt > 0) begin
      skel_cnt <= skel_cnt - 1;
      if (skel_cnt == 1) begin
        dut_valid    <= 1'b1;
        dut_data_out <= skel_hold;
      end
    end
  end

  // scoreboard
  int n_vec = 0;
  int n_mis = 0;
  logic [HEAD:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Transaction-level reference: what the host should see for each command.
  logic           m_en = 1'b0;
  logic [15:0]    m_run = '0;
  logic [15:0]    m_err = '0;
  logic [SYS-1:0] m_din = '0;

  task automatic model_cmd(input logic [1:0] op, input logic [SYS-1:0] d, input logic [HEAD-1:0] head,
                           input int lat, output int e_lat, output int e_trg);
    logic [HEAD:0] e;
    e_trg = 0;
    e_lat = 1;
    case (op)
      OP_HEAD:  e = {1'b0, head};
      OP_SETEN: begin m_en = d[0]; e = {1'b0, HEAD'(d[0])}; end
      OP_STAT:  e = {1'b0, HEAD'({m_err[7:0], m_run[7:0]})};
      default: begin
        if (!m_en) begin
          m_err = m_err + 16'd1;
          e = {1'b1, {HEAD{1'b0}}};
        end else begin
          m_din = d;
          e_trg = 1;
          if (lat >= 1 && lat <= TO + 1) begin
            m_run = m_run + 16'd1;
            e = {1'b0, HEAD'(d)};
            e_lat = lat + 2;
          end else begin
            m_err = m_err + 16'd1;
            e = {1'b1, {HEAD{1'b0}}};
            e_lat = TO + 3;
          end
        end
      end
    endcase
    exp_q.push_back(e);
  endtask

  // driver: issue one command, collect response, optional backpressure, handshake
  task automatic do_cmd(input logic [1:0] op, input logic [SYS-1:0] d, input int hold,
                        output logic [HEAD-1:0] rd, output logic re, output int lat,
                        output int ntrg, output int tcyc);
    int cyc;
    int bad;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = SYS'($urandom);
    cyc = 1; ntrg = 0; tcyc = -1; lat = -1;
    while (cyc < 100) begin
      if (dut_trgg) begin
        ntrg++;
        if (tcyc < 0) tcyc = cyc;
      end
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd = rsp_data;
    re = rsp_err;
    if (lat < 0) begin
      n_vec++; n_mis++;
      $display("FAIL rsp_timeout: got no RSP_VALID expected one within 100 cycles");
    end
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== rd || rsp_err !== re || cmd_ready !== 1'b0 || dut_trgg !== 1'b0)
        bad++;
    end
    if (hold > 0) check("bp_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [SYS-1:0]  data;
    logic [HEAD-1:0] head;
    int              lat;
    int              hold;
    logic [HEAD-1:0] exp_data;
    logic            exp_err;
    int              exp_lat;
    int              exp_trg;
  } vec_t;

  vec_t vecs[16];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2 ms");
    $fatal(1);
  end

  initial begin : main
    logic [HEAD-1:0] rd;
    logic            re;
    int              lat, ntrg, tcyc, e_lat, e_trg;
    logic [HEAD:0]   e;
    int              bad;

    vecs[0]  = '{OP_HEAD,  16'h0000, 26'h0104150, 1, 0,  26'h0104150, 1'b0, 1,  0};
    vecs[1]  = '{OP_RUN,   16'h1234, 26'h0000000, 1, 0,  26'h0000000, 1'b1, 1,  0};
    vecs[2]  = '{OP_STAT,  16'h0000, 26'h0000000, 1, 0,  26'h0000100, 1'b0, 1,  0};
    vecs[3]  = '{OP_SETEN, 16'h0001, 26'h0000000, 1, 0,  26'h0000001, 1'b0, 1,  0};
    vecs[4]  = '{OP_RUN,   16'hA5C3, 26'h0000000, 1, 20, 26'h000A5C3, 1'b0, 3,  1};
    vecs[5]  = '{OP_STAT,  16'h0000, 26'h0000000, 1, 0,  26'h0000101, 1'b0, 1,  0};
    vecs[6]  = '{OP_RUN,   16'h5A5A, 26'h0000000, 0, 0,  26'h0000000, 1'b1, 11, 1};
    vecs[7]  = '{OP_STAT,  16'h0000, 26'h0000000, 1, 0,  26'h0000201, 1'b0, 1,  0};
    vecs[8]  = '{OP_RUN,   16'hBEEF, 26'h0000000, 4, 0,  26'h000BEEF, 1'b0, 6,  1};
    vecs[9]  = '{OP_RUN,   16'h0F0F, 26'h0000000, 9, 0,  26'h0000F0F, 1'b0, 11, 1};
    vecs[10] = '{OP_RUN,   16'h7777, 26'h0000000, 10, 0, 26'h0000000, 1'b1, 11, 1};
    vecs[11] = '{OP_STAT,  16'h0000, 26'h0000000, 1, 0,  26'h0000303, 1'b0, 1,  0};
    vecs[12] = '{OP_SETEN, 16'hFFFE, 26'h0000000, 1, 3,  26'h0000000, 1'b0, 1,  0};
    vecs[13] = '{OP_RUN,   16'h0001, 26'h0000000, 1, 0,  26'h0000000, 1'b1, 1,  0};
    vecs[14] = '{OP_HEAD,  16'h0000, 26'h3FFFFFF, 1, 0,  26'h3FFFFFF, 1'b0, 1,  0};
    vecs[15] = '{OP_STAT,  16'h0000, 26'h0000000, 1, 0,  26'h0000403, 1'b0, 1,  0};

    // reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_dut_en",    32'(dut_en),    32'd0);
    check("rst_dut_trgg",  32'(dut_trgg),  32'd0);
    check("rst_data_in",   32'(dut_data_in), 32'd0);
    check("rst_cnts",      {dbg_err_cnt, dbg_run_cnt}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      skel_lat = vecs[i].lat;
      dut_head = vecs[i].head;
      model_cmd(vecs[i].op, vecs[i].data, vecs[i].head, vecs[i].lat, e_lat, e_trg);
      void'(exp_q.pop_front());
      do_cmd(vecs[i].op, vecs[i].data, vecs[i].hold, rd, re, lat, ntrg, tcyc);
      check($sformatf("vec%0d_data", i), 32'(rd),   32'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i),  32'(re),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i),  32'(lat),  32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_trg", i),  32'(ntrg), 32'(vecs[i].exp_trg));
      if (vecs[i].exp_trg == 1) check($sformatf("vec%0d_trg_cyc", i), 32'(tcyc), 32'd1);
    end
    check("din_held", 32'(dut_data_in), 32'h7777);
    check("en_after_clear", 32'(dut_en), 32'd0);

    // random commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]      op;
      logic [SYS-1:0]  d;
      logic [HEAD-1:0] h;
      int              l, hd;
      op = 2'($urandom_range(0, 3));
      d  = SYS'($urandom);
      h  = HEAD'($urandom);
      l  = $urandom_range(0, 10);
      hd = $urandom_range(0, 3);
      if (op == OP_SETEN && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      skel_lat = l;
      dut_head = h;
      model_cmd(op, d, h, l, e_lat, e_trg);
      do_cmd(op, d, hd, rd, re, lat, ntrg, tcyc);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_rsp", i), 32'({re, rd}), 32'(e));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(e_lat));
      check($sformatf("rnd%0d_trg", i), 32'(ntrg), 32'(e_trg));
      check($sformatf("rnd%0d_din", i), 32'(dut_data_in), 32'(m_din));
      check($sformatf("rnd%0d_cnts", i), {dbg_err_cnt, dbg_run_cnt}, {m_err, m_run});
    end

    // reset during WAIT: run aborted, late skeleton result ignored
    skel_lat = 1;
    model_cmd(OP_SETEN, 16'h0001, '0, 1, e_lat, e_trg);
    void'(exp_q.pop_front());
    do_cmd(OP_SETEN, 16'h0001, 0, rd, re, lat, ntrg, tcyc);
    check("rw_en_set", 32'(dut_en), 32'd1);
    skel_lat  = 5;
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    cmd_data  = 16'hC0DE;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rw_trig", 32'(dut_trgg), 32'd1);
    @(posedge clk); #1;
    check("rw_waiting", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rw_dut_en",    32'(dut_en),    32'd0);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rw_run_cnt",   32'(dbg_run_cnt), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || dut_trgg !== 1'b0) bad++;
    end
    check("rw_late_valid_ignored", 32'(bad), 32'd0);
    m_en = 1'b0; m_run = '0; m_err = '0; m_din = '0;
    model_cmd(OP_STAT, '0, '0, 1, e_lat, e_trg);
    do_cmd(OP_STAT, '0, 0, rd, re, lat, ntrg, tcyc);
    e = exp_q.pop_front();
    check("rw_stat", 32'({re, rd}), 32'(e));
    check("rw_stat_lat", 32'(lat), 32'(e_lat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
